// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the memory-port arbiter: FSM encodings, requester
// indices and the read value returned when an access times out.
package mem_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_t;

  localparam int REQ_FETCH = 0;
  localparam int REQ_DATA  = 1;
  localparam int REQ_DEBUG = 2;

  localparam logic [7:0] ERR_RDATA = 8'hFF;
  localparam int         CNT_W     = 8;

endpackage

// File: rtl/mem_arbiter_rr_pick.sv
// Combinational round-robin selector: first set request at or above ptr,
// wrapping modulo N. Reusable for any shared resource.
module rr_pick #(
  parameter int N     = 3,
  parameter int PTR_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req,
  input  logic [PTR_W-1:0] ptr,
  output logic [N-1:0]     onehot,
  output logic [PTR_W-1:0] index
);

  int   w_j;
  logic w_found;

  always_comb begin
    onehot  = '0;
    index   = '0;
    w_found = 1'b0;
    w_j     = 0;
    for (int k = 0; k < N; k++) begin
      w_j = int'(ptr) + k;
      if (w_j >= N) w_j = w_j - N;
      if (!w_found && req[w_j]) begin
        w_found     = 1'b1;
        onehot[w_j] = 1'b1;
        index       = PTR_W'(w_j);
      end
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one 8-bit memory port between NUM_REQ
// requesters, one outstanding access, with a timeout on mem_ready.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 3,
  parameter int ADDR_W  = 8,
  parameter int TIMEOUT = 15
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ-1:0]        we,
  input  logic [NUM_REQ*ADDR_W-1:0] addr,
  input  logic [NUM_REQ*8-1:0]      wdata,
  output logic [NUM_REQ-1:0]        gnt,
  output logic [NUM_REQ-1:0]        ack,
  output logic [7:0]                rdata,
  output logic                      err,
  output logic                      busy,
  output logic                      mem_cs,
  output logic                      mem_we,
  output logic [ADDR_W-1:0]         mem_addr,
  output logic [7:0]                mem_wdata,
  input  logic [7:0]                mem_rdata,
  input  logic                      mem_ready
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  state_t             r_state, w_state_next;
  logic [PTR_W-1:0]   r_ptr, w_ptr_next;
  logic [PTR_W-1:0]   r_idx, w_idx_next;
  logic [NUM_REQ-1:0] r_gnt, w_gnt_next;
  logic [NUM_REQ-1:0] r_ack, w_ack_next;
  logic               r_err, w_err_next;
  logic [7:0]         r_rdata, w_rdata_next;
  logic [CNT_W-1:0]   r_cnt, w_cnt_next;
  logic               r_mem_we, w_mem_we_next;
  logic [ADDR_W-1:0]  r_mem_addr, w_mem_addr_next;
  logic [7:0]         r_mem_wdata, w_mem_wdata_next;

  logic [NUM_REQ-1:0] w_pick_onehot;
  logic [PTR_W-1:0]   w_pick_idx;

  rr_pick #(.N(NUM_REQ), .PTR_W(PTR_W)) u_rr_pick (
    .req    (req),
    .ptr    (r_ptr),
    .onehot (w_pick_onehot),
    .index  (w_pick_idx)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_ptr       <= '0;
      r_idx       <= '0;
      r_gnt       <= '0;
      r_ack       <= '0;
      r_err       <= 1'b0;
      r_rdata     <= '0;
      r_cnt       <= '0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
    end else begin
      r_state     <= w_state_next;
      r_ptr       <= w_ptr_next;
      r_idx       <= w_idx_next;
      r_gnt       <= w_gnt_next;
      r_ack       <= w_ack_next;
      r_err       <= w_err_next;
      r_rdata     <= w_rdata_next;
      r_cnt       <= w_cnt_next;
      r_mem_we    <= w_mem_we_next;
      r_mem_addr  <= w_mem_addr_next;
      r_mem_wdata <= w_mem_wdata_next;
    end
  end

  always_comb begin
    w_state_next     = r_state;
    w_ptr_next       = r_ptr;
    w_idx_next       = r_idx;
    w_gnt_next       = r_gnt;
    w_ack_next       = '0;
    w_err_next       = 1'b0;
    w_rdata_next     = r_rdata;
    w_cnt_next       = r_cnt;
    w_mem_we_next    = r_mem_we;
    w_mem_addr_next  = r_mem_addr;
    w_mem_wdata_next = r_mem_wdata;
    case (r_state)
      ST_IDLE: begin
        if (|req) begin
          w_gnt_next       = w_pick_onehot;
          w_idx_next       = w_pick_idx;
          w_mem_we_next    = we[w_pick_idx];
          w_mem_addr_next  = addr[w_pick_idx*ADDR_W +: ADDR_W];
          w_mem_wdata_next = wdata[w_pick_idx*8 +: 8];
          w_cnt_next       = '0;
          w_state_next     = ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        w_cnt_next = r_cnt + 1'b1;
        // mem_ready takes priority over a coincident timeout
        if (mem_ready) begin
          if (!r_mem_we) w_rdata_next = mem_rdata;
          w_ack_next   = r_gnt;
          w_state_next = ST_RESP;
        end else if (r_cnt == CNT_W'(TIMEOUT - 1)) begin
          if (!r_mem_we) w_rdata_next = ERR_RDATA;
          w_ack_next   = r_gnt;
          w_err_next   = 1'b1;
          w_state_next = ST_RESP;
        end
      end
      ST_RESP: begin
        w_ptr_next   = (r_idx == PTR_W'(NUM_REQ - 1)) ? '0 : r_idx + 1'b1;
        w_gnt_next   = '0;
        w_state_next = ST_IDLE;
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  assign gnt       = r_gnt;
  assign ack       = r_ack;
  assign err       = r_err;
  assign rdata     = r_rdata;
  assign busy      = (r_state != ST_IDLE);
  assign mem_cs    = (r_state == ST_ACCESS);
  assign mem_we    = r_mem_we;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;

endmodule
